// File: rtl/rtc_field_editor_pkg.sv
// Field map and per-field BCD limits for the RTC edit path, plus the
// small lookups the editor uses to classify and bound the selected field.
package rtc_edit_pkg;

    localparam logic [7:0] ADDR_MODE  = 8'h00;
    localparam logic [7:0] ADDR_SEC   = 8'h21;
    localparam logic [7:0] ADDR_MIN   = 8'h22;
    localparam logic [7:0] ADDR_HOUR  = 8'h23;
    localparam logic [7:0] ADDR_DATE  = 8'h24;
    localparam logic [7:0] ADDR_MONTH = 8'h25;
    localparam logic [7:0] ADDR_YEAR  = 8'h26;
    localparam logic [7:0] ADDR_DOW   = 8'h27;
    localparam logic [7:0] ADDR_WEEK  = 8'h28;

    localparam logic [7:0] MIN_MODE  = 8'h00;  localparam logic [7:0] MAX_MODE  = 8'h01;
    localparam logic [7:0] MIN_SEC   = 8'h00;  localparam logic [7:0] MAX_SEC   = 8'h59;
    localparam logic [7:0] MIN_MIN   = 8'h00;  localparam logic [7:0] MAX_MIN   = 8'h59;
    localparam logic [7:0] MIN_HOUR  = 8'h00;  localparam logic [7:0] MAX_HOUR  = 8'h23;
    localparam logic [7:0] MIN_DATE  = 8'h01;  localparam logic [7:0] MAX_DATE  = 8'h31;
    localparam logic [7:0] MIN_MONTH = 8'h01;  localparam logic [7:0] MAX_MONTH = 8'h12;
    localparam logic [7:0] MIN_YEAR  = 8'h00;  localparam logic [7:0] MAX_YEAR  = 8'h99;
    localparam logic [7:0] MIN_DOW   = 8'h01;  localparam logic [7:0] MAX_DOW   = 8'h07;
    localparam logic [7:0] MIN_WEEK  = 8'h01;  localparam logic [7:0] MAX_WEEK  = 8'h52;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_HOLD,
        ST_WR_REQ
    } state_e;

    function automatic logic is_edit_addr(input logic [7:0] addr);
        return (addr == ADDR_MODE) || ((addr >= ADDR_SEC) && (addr <= ADDR_WEEK));
    endfunction

    function automatic logic [7:0] field_min(input logic [7:0] addr);
        case (addr)
            ADDR_DATE:  return MIN_DATE;
            ADDR_MONTH: return MIN_MONTH;
            ADDR_DOW:   return MIN_DOW;
            ADDR_WEEK:  return MIN_WEEK;
            default:    return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] field_max(input logic [7:0] addr);
        case (addr)
            ADDR_MODE:  return MAX_MODE;
            ADDR_SEC:   return MAX_SEC;
            ADDR_MIN:   return MAX_MIN;
            ADDR_HOUR:  return MAX_HOUR;
            ADDR_DATE:  return MAX_DATE;
            ADDR_MONTH: return MAX_MONTH;
            ADDR_YEAR:  return MAX_YEAR;
            ADDR_DOW:   return MAX_DOW;
            ADDR_WEEK:  return MAX_WEEK;
            default:    return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/rtc_field_editor_if.sv
// Request/acknowledge register bus between the field editor (master) and the RTC (slave).
interface rtc_field_editor_if #(
    parameter int AW = 8
);
    logic          req;
    logic          we;
    logic [AW-1:0] req_addr;
    logic [AW-1:0] wdata;
    logic [AW-1:0] rdata;
    logic          ack;

    modport master (output req, we, req_addr, wdata, input rdata, ack);
    modport slave  (input req, we, req_addr, wdata, output rdata, ack);
endinterface

// File: rtl/rtc_field_editor_bcd_step.sv
// Combinational packed-BCD +/-1 with inclusive [min,max] wrap; illegal or
// out-of-range inputs snap to min (increment) or max (decrement).
module bcd_step (
    input  logic [7:0] val_i,
    input  logic [7:0] min_i,
    input  logic [7:0] max_i,
    input  logic       dir_i,
    output logic [7:0] next_o
);
    logic legal;

    assign legal = (val_i[7:4] <= 4'd9) && (val_i[3:0] <= 4'd9) &&
                   (val_i >= min_i) && (val_i <= max_i);

    always_comb begin
        next_o = min_i;
        if (!legal) begin
            next_o = dir_i ? min_i : max_i;
        end else if (dir_i) begin
            if (val_i == max_i)
                next_o = min_i;
            else if (val_i[3:0] == 4'd9)
                next_o = {val_i[7:4] + 4'd1, 4'd0};
            else
                next_o = {val_i[7:4], val_i[3:0] + 4'd1};
        end else begin
            if (val_i == min_i)
                next_o = max_i;
            else if (val_i[3:0] == 4'd0)
                next_o = {val_i[7:4] - 4'd1, 4'd9};
            else
                next_o = {val_i[7:4], val_i[3:0] - 4'd1};
        end
    end
endmodule

// File: rtl/rtc_field_editor.sv
// Reads the selected RTC field, applies BCD +/-1 on suma/resta edges,
// writes the result back and exposes the edited value to the display.
module rtc_field_editor
    import rtc_edit_pkg::*;
#(
    parameter int ACK_TIMEOUT = 64,
    parameter int AW          = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                escribe,
    input  logic [AW-1:0]       address,
    input  logic                suma,
    input  logic                resta,
    rtc_field_editor_if.master  bus,
    output logic [AW-1:0]       value,
    output logic                valid,
    output logic                err
);
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_e          state_q, state_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [AW-1:0]   req_addr_q, req_addr_d;
    logic [AW-1:0]   wdata_q, wdata_d;
    logic [AW-1:0]   value_q, value_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic [AW-1:0]   cur_addr_q, cur_addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            suma_q, resta_q, escribe_q;

    logic            suma_rise, resta_rise, esc_rise;
    logic [7:0]      step_min, step_max, step_val;

    assign suma_rise  = suma & ~suma_q;
    assign resta_rise = resta & ~resta_q;
    assign esc_rise   = escribe & ~escribe_q;
    assign step_min   = field_min(cur_addr_q);
    assign step_max   = field_max(cur_addr_q);

    bcd_step u_step (
        .val_i  (value_q),
        .min_i  (step_min),
        .max_i  (step_max),
        .dir_i  (suma_rise),
        .next_o (step_val)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        req_addr_d = req_addr_q;
        wdata_d    = wdata_q;
        value_d    = value_q;
        valid_d    = valid_q;
        cur_addr_d = cur_addr_q;
        cnt_d      = cnt_q;
        err_d      = esc_rise ? 1'b0 : err_q;

        case (state_q)
            ST_IDLE: begin
                if (escribe) begin
                    if (is_edit_addr(address)) begin
                        state_d    = ST_RD_REQ;
                        req_d      = 1'b1;
                        we_d       = 1'b0;
                        req_addr_d = address;
                        cnt_d      = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RD_REQ: begin
                if (bus.ack) begin
                    req_d   = 1'b0;
                    value_d = bus.rdata;
                    // Latch the address actually read, so a mid-read field change triggers a re-read.
                    cur_addr_d = req_addr_q;
                    valid_d    = escribe;
                    state_d    = escribe ? ST_HOLD : ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (!escribe) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end else if (address != cur_addr_q) begin
                    valid_d = 1'b0;
                    if (is_edit_addr(address)) begin
                        state_d    = ST_RD_REQ;
                        req_d      = 1'b1;
                        we_d       = 1'b0;
                        req_addr_d = address;
                        cnt_d      = '0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (suma_rise ^ resta_rise) begin
                    value_d    = step_val;
                    wdata_d    = step_val;
                    req_d      = 1'b1;
                    we_d       = 1'b1;
                    req_addr_d = cur_addr_q;
                    cnt_d      = '0;
                    state_d    = ST_WR_REQ;
                end
            end
            ST_WR_REQ: begin
                if (bus.ack) begin
                    req_d   = 1'b0;
                    valid_d = escribe;
                    state_d = escribe ? ST_HOLD : ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            req_addr_q <= '0;
            wdata_q    <= '0;
            value_q    <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            cur_addr_q <= '0;
            cnt_q      <= '0;
            suma_q     <= 1'b0;
            resta_q    <= 1'b0;
            escribe_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            req_addr_q <= req_addr_d;
            wdata_q    <= wdata_d;
            value_q    <= value_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            cur_addr_q <= cur_addr_d;
            cnt_q      <= cnt_d;
            suma_q     <= suma;
            resta_q    <= resta;
            escribe_q  <= escribe;
        end
    end

    assign bus.req      = req_q;
    assign bus.we       = we_q;
    assign bus.req_addr = req_addr_q;
    assign bus.wdata    = wdata_q;
    assign value        = value_q;
    assign valid        = valid_q;
    assign err          = err_q;

endmodule

// File: tb/tb_rtc_field_editor.sv
// Directed bench for rtc_field_editor: an RTC register-file responder, an
// arithmetic BCD reference model and a per-cycle monitor of bus and display outputs.
module tb_rtc_field_editor;

    logic       clk = 1'b0;
    logic       reset, escribe, suma, resta;
    logic [7:0] address, value;
    logic       valid, err;

    rtc_field_editor_if bus ();

    rtc_field_editor dut (
        .clk     (clk),
        .reset   (reset),
        .escribe (escribe),
        .address (address),
        .suma    (suma),
        .resta   (resta),
        .bus     (bus),
        .value   (value),
        .valid   (valid),
        .err     (err)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] mem [0:255];
    int         resp_delay = 2;
    bit         resp_en = 1'b1;
    bit         last_up = 1'b1;
    logic [7:0] last_addr = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: decode BCD to an integer, step with modular wrap, re-encode.
    function automatic logic [7:0] ref_step(input logic [7:0] addr, input logic [7:0] v, input bit up);
        int lo, hi, n, tens, units;
        case (addr)
            8'h00: begin lo = 0; hi = 1;  end
            8'h21: begin lo = 0; hi = 59; end
            8'h22: begin lo = 0; hi = 59; end
            8'h23: begin lo = 0; hi = 23; end
            8'h24: begin lo = 1; hi = 31; end
            8'h25: begin lo = 1; hi = 12; end
            8'h26: begin lo = 0; hi = 99; end
            8'h27: begin lo = 1; hi = 7;  end
            8'h28: begin lo = 1; hi = 52; end
            default: begin lo = 0; hi = 0; end
        endcase
        tens  = int'(v[7:4]);
        units = int'(v[3:0]);
        n     = tens * 10 + units;
        if (tens > 9 || units > 9 || n < lo || n > hi)
            n = up ? lo : hi;
        else if (up)
            n = (n == hi) ? lo : n + 1;
        else
            n = (n == lo) ? hi : n - 1;
        return 8'((n / 10) * 16 + (n % 10));
    endfunction

    // RTC responder: acks after resp_delay cycles of req, serves reads and commits writes.
    initial begin
        int wcnt;
        wcnt = 0;
        bus.ack = 1'b0;
        bus.rdata = 8'h00;
        forever begin
            @(negedge clk);
            bus.ack = 1'b0;
            if (bus.req === 1'b1 && resp_en && reset === 1'b0) begin
                if (wcnt >= resp_delay) begin
                    bus.ack = 1'b1;
                    if (bus.we === 1'b1) mem[bus.req_addr] = bus.wdata;
                    else bus.rdata = mem[bus.req_addr];
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Per-cycle monitor: request stability, written data vs model, displayed value vs RTC contents.
    initial begin
        logic       req_p;
        logic       we_p;
        logic [7:0] a_p, w_p;
        req_p = 1'b0; we_p = 1'b0; a_p = 8'h00; w_p = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.req === 1'b1) begin
                if (req_p) begin
                    chk("req_addr_stable", bus.req_addr, a_p);
                    chk("we_stable", bus.we, we_p);
                    if (bus.we === 1'b1) chk("wdata_stable", bus.wdata, w_p);
                end else if (bus.we === 1'b1) begin
                    chk("wdata_model", bus.wdata, ref_step(bus.req_addr, mem[bus.req_addr], last_up));
                end
                if (valid === 1'b1 && bus.we === 1'b1) chk("value_eq_wdata", value, bus.wdata);
                last_addr = bus.req_addr;
            end else if (valid === 1'b1) begin
                chk("value_vs_rtc", value, mem[last_addr]);
            end
            req_p = (bus.req === 1'b1);
            we_p  = bus.we;
            a_p   = bus.req_addr;
            w_p   = bus.wdata;
        end
    end

    task automatic expect_txn(input string name, input logic w, input logic [7:0] a, input logic [7:0] d);
        for (int i = 0; i < 100 && bus.req !== 1'b1; i++) @(negedge clk);
        chk({name, "_req"}, bus.req, 1'b1);
        chk({name, "_we"}, bus.we, w);
        chk({name, "_addr"}, bus.req_addr, a);
        if (w) chk({name, "_wdata"}, bus.wdata, d);
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 200 && bus.req === 1'b1; i++) @(negedge clk);
        chk({name, "_req_drop"}, bus.req, 1'b0);
    endtask

    task automatic no_req(input string name, input int n);
        bit seen;
        seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (bus.req === 1'b1) seen = 1'b1;
        end
        chk(name, seen, 1'b0);
    endtask

    task automatic select_field(input logic [7:0] a, input logic [7:0] v);
        mem[a] = v;
        @(negedge clk);
        address = a;
        expect_txn("sel_rd", 1'b0, a, 8'h00);
        wait_done("sel_rd");
        chk("sel_value", value, v);
        chk("sel_valid", valid, 1'b1);
    endtask

    task automatic step(input bit up, input logic [7:0] exp);
        last_up = up;
        @(negedge clk);
        if (up) suma = 1'b1; else resta = 1'b1;
        @(negedge clk);
        suma = 1'b0;
        resta = 1'b0;
        expect_txn("step_wr", 1'b1, address, exp);
        wait_done("step_wr");
        chk("step_value", value, exp);
        chk("step_rtc", mem[address], exp);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_req"}, bus.req, 1'b0);
        chk({name, "_we"}, bus.we, 1'b0);
        chk({name, "_req_addr"}, bus.req_addr, 8'h00);
        chk({name, "_wdata"}, bus.wdata, 8'h00);
        chk({name, "_value"}, value, 8'h00);
        chk({name, "_valid"}, valid, 1'b0);
        chk({name, "_err"}, err, 1'b0);
    endtask

    initial begin
        int cnt;
        reset = 1'b1; escribe = 1'b0; address = 8'h00; suma = 1'b0; resta = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");

        chk("model_sec_up_wrap",  ref_step(8'h21, 8'h59, 1'b1), 8'h00);
        chk("model_sec_dn_wrap",  ref_step(8'h21, 8'h00, 1'b0), 8'h59);
        chk("model_date_dn",      ref_step(8'h24, 8'h01, 1'b0), 8'h31);
        chk("model_month_up",     ref_step(8'h25, 8'h12, 1'b1), 8'h01);
        chk("model_carry",        ref_step(8'h21, 8'h09, 1'b1), 8'h10);
        chk("model_borrow",       ref_step(8'h21, 8'h10, 1'b0), 8'h09);
        chk("model_oor_up",       ref_step(8'h26, 8'h7A, 1'b1), 8'h00);
        chk("model_oor_dn",       ref_step(8'h23, 8'h7A, 1'b0), 8'h23);

        // Read path
        reset = 1'b0;
        mem[8'h21] = 8'h37;
        address = 8'h21;
        escribe = 1'b1;
        expect_txn("rd1", 1'b0, 8'h21, 8'h00);
        wait_done("rd1");
        chk("rd1_value", value, 8'h37);
        chk("rd1_valid", valid, 1'b1);
        step(1'b1, 8'h38);

        // Wraps across fields
        select_field(8'h24, 8'h01); step(1'b0, 8'h31);
        select_field(8'h21, 8'h59); step(1'b1, 8'h00); step(1'b0, 8'h59);
        select_field(8'h25, 8'h12); step(1'b1, 8'h01);
        select_field(8'h28, 8'h52); step(1'b1, 8'h01);
        select_field(8'h27, 8'h07); step(1'b1, 8'h01);
        select_field(8'h00, 8'h01); step(1'b1, 8'h00);

        // Simultaneous edges cancel
        @(negedge clk); suma = 1'b1; resta = 1'b1;
        @(negedge clk); suma = 1'b0; resta = 1'b0;
        no_req("both_edges_no_write", 10);
        chk("both_edges_value", value, 8'h00);

        // Out-of-range read data
        select_field(8'h26, 8'h7A); step(1'b1, 8'h00);
        select_field(8'h23, 8'h7A); step(1'b0, 8'h23);

        // Field change while holding; pulse during the read is dropped
        select_field(8'h22, 8'h15);
        resp_delay = 6;
        @(negedge clk); address = 8'h23;
        @(negedge clk);
        chk("fc_valid_low", valid, 1'b0);
        chk("fc_rd_req", bus.req, 1'b1);
        chk("fc_rd_addr", bus.req_addr, 8'h23);
        chk("fc_rd_we", bus.we, 1'b0);
        suma = 1'b1;
        @(negedge clk); suma = 1'b0;
        wait_done("fc_rd");
        resp_delay = 2;
        no_req("fc_no_write", 10);
        chk("fc_value", value, 8'h23);
        chk("fc_valid", valid, 1'b1);

        // Ack timeout
        resp_en = 1'b0;
        @(negedge clk); address = 8'h21;
        for (int i = 0; i < 100 && bus.req !== 1'b1; i++) @(negedge clk);
        cnt = 0;
        while (bus.req === 1'b1 && cnt < 200) begin
            cnt++;
            if (cnt == 10) escribe = 1'b0;
            @(negedge clk);
        end
        chk("to_req_cycles", cnt, 64);
        chk("to_req_low", bus.req, 1'b0);
        chk("to_err", err, 1'b1);
        chk("to_valid", valid, 1'b0);
        no_req("to_idle", 5);
        resp_en = 1'b1;

        // Unsupported address, then err cleared by escribe rising
        address = 8'h10; escribe = 1'b1;
        @(negedge clk);
        chk("bad_addr_err", err, 1'b1);
        no_req("bad_addr_no_req", 10);
        escribe = 1'b0;
        @(negedge clk);
        address = 8'h21; escribe = 1'b1;
        @(negedge clk);
        chk("err_cleared", err, 1'b0);
        chk("reread_req", bus.req, 1'b1);
        wait_done("reread");
        chk("reread_value", value, 8'h59);
        chk("reread_valid", valid, 1'b1);

        // escribe falls during a write: write completes, then idle
        resp_delay = 5;
        last_up = 1'b1;
        @(negedge clk); suma = 1'b1;
        @(negedge clk); suma = 1'b0;
        expect_txn("abort_wr", 1'b1, 8'h21, 8'h00);
        escribe = 1'b0;
        wait_done("abort_wr");
        chk("abort_wr_committed", mem[8'h21], 8'h00);
        chk("abort_valid", valid, 1'b0);
        no_req("abort_idle", 10);

        // Reset during a read
        resp_delay = 20;
        address = 8'h22; escribe = 1'b1;
        expect_txn("rst_rd", 1'b0, 8'h22, 8'h00);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midrst");
        reset = 1'b0; escribe = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
